branch_ctrl: RTL and testbench

- Branch-resolution block that drives the program counter's `branchFlag` and `target` inputs. It is the producer side of the PC's jump interface.
- Tracks the instruction slot phase (`PHASES` clocks per instruction) and latches one branch request from decode per slot.
- Resolves the condition and the jump target from a programmable lookup table (LUT). Presents `branchFlag`/`target` for exactly the PC's update cycle.

---
 rtl/branch_ctrl.sv | 143 ++++++++++++++
 tb/tb_branch_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution for the PC jump interface: latches one decode request per slot and asserts branchFlag/target in the slot's last phase.
// Optional taken/not-taken/dropped counters are enabled with BRANCH_CTRL_STATS_EN.
module branch_ctrl #(
  parameter int D        = 12,
  parameter int PHASES   = 5,
  parameter int LUT_SIZE = 32,
  parameter int LW       = $clog2(LUT_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [D-1:0]  prog_ctr,
  input  logic          br_req,
  input  logic [1:0]    br_mode,
  input  logic          br_cond,
  input  logic [LW-1:0] br_idx,
  input  logic          lut_we,
  input  logic [LW-1:0] lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic          branchFlag,
  output logic [D-1:0]  target,
  output logic [2:0]    phase,
  output logic          busy
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [15:0]   taken_cnt,
  output logic [15:0]   nottaken_cnt,
  output logic [15:0]   dropped_cnt
`endif
);

  localparam logic [2:0] PH_LAST = 3'(PHASES - 1);
  localparam logic [2:0] PH_PEN  = 3'(PHASES - 2);

  typedef enum logic [1:0] {IDLE, PENDING, FIRE} state_t;

  state_t         state, state_nx;
  logic           capture;
  logic           taken_r;
  logic           taken_nx;
  logic [D-1:0]   lut_rd;
  logic [D-1:0]   tgt_nx;
  logic [D-1:0]   lut [LUT_SIZE];

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (phase == PH_LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + 3'd1;
    end
  end

  // A capture in the phase just before the assert slot must go straight to FIRE.
  always_comb begin
    capture  = 1'b0;
    state_nx = state;
    case (state)
      IDLE: begin
        if (br_req && (phase <= PH_PEN)) begin
          capture  = 1'b1;
          state_nx = (phase == PH_PEN) ? FIRE : PENDING;
        end
      end
      PENDING: begin
        if (phase == PH_PEN) begin
          state_nx = FIRE;
        end
      end
      FIRE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Relative targets add the LUT entry as a signed offset; D-bit wrap is intended.
  always_comb begin
    lut_rd = lut[br_idx];
    tgt_nx = (br_mode == 2'b11) ? (prog_ctr + lut_rd) : lut_rd;
    case (br_mode)
      2'b01:   taken_nx = br_cond;
      2'b10:   taken_nx = !br_cond;
      default: taken_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target  <= '0;
      taken_r <= 1'b0;
    end else if (capture) begin
      target  <= tgt_nx;
      taken_r <= taken_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_SIZE; i++) begin
        lut[i] <= '0;
      end
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  assign branchFlag = (state == FIRE) && taken_r;
  assign busy       = (state != IDLE);

`ifdef BRANCH_CTRL_STATS_EN
  logic fire_taken, fire_nottaken, dropped;

  assign fire_taken    = (state == FIRE) && taken_r;
  assign fire_nottaken = (state == FIRE) && !taken_r;
  assign dropped       = br_req && !capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt    <= '0;
      nottaken_cnt <= '0;
      dropped_cnt  <= '0;
    end else begin
      if (fire_taken && (taken_cnt != 16'hFFFF)) begin
        taken_cnt <= taken_cnt + 16'd1;
      end
      if (fire_nottaken && (nottaken_cnt != 16'hFFFF)) begin
        nottaken_cnt <= nottaken_cnt + 16'd1;
      end
      if (dropped && (dropped_cnt != 16'hFFFF)) begin
        dropped_cnt <= dropped_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: expected {flag,target} pushed per accepted request, popped at each FIRE cycle.
module tb_branch_ctrl;
  localparam int D = 12;
  localparam int LW = 5;
  localparam logic [2:0] LAST = 3'd4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [D-1:0]  prog_ctr = '0;
  logic          br_req = 1'b0;
  logic [1:0]    br_mode = '0;
  logic          br_cond = 1'b0;
  logic [LW-1:0] br_idx = '0;
  logic          lut_we = 1'b0;
  logic [LW-1:0] lut_waddr = '0;
  logic [D-1:0]  lut_wdata = '0;
  logic          branchFlag;
  logic [D-1:0]  target;
  logic [2:0]    phase;
  logic          busy;
`ifdef BRANCH_CTRL_STATS_EN
  logic [15:0]   taken_cnt, nottaken_cnt, dropped_cnt;
`endif

  int total = 0;
  int bad = 0;
  int exp_taken = 0;
  int exp_nt = 0;
  int exp_drop = 0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_e;
  logic [D-1:0] lut_m [32];

  always #5 clk = ~clk;

  branch_ctrl dut (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .br_req(br_req), .br_mode(br_mode),
    .br_cond(br_cond), .br_idx(br_idx), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .branchFlag(branchFlag), .target(target), .phase(phase), .busy(busy)
`ifdef BRANCH_CTRL_STATS_EN
    , .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt), .dropped_cnt(dropped_cnt)
`endif
  );

  // Scoreboard monitor: every FIRE cycle consumes one expected result.
  always @(negedge clk) begin
    total++;
    if (branchFlag && (phase !== LAST)) begin
      bad++;
      $display("FAIL flag_phase: branchFlag=1 at phase=%0d, required phase %0d", phase, LAST);
    end
    if (busy && (phase === LAST)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_fire: flag=%0b target=%h, required no fire", branchFlag, target);
      end else begin
        mon_e = exp_q.pop_front();
        if ({branchFlag, target} !== mon_e) begin
          bad++;
          $display("FAIL fire: flag=%0b target=%h, required flag=%0b target=%h",
                   branchFlag, target, mon_e[12], mon_e[11:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] expect_of(input logic [1:0] m, input logic c,
                                            input logic [4:0] idx, input logic [11:0] pc);
    logic t;
    logic [11:0] g;
    t = (m == 2'b01) ? c : (m == 2'b10) ? !c : 1'b1;
    g = (m == 2'b11) ? 12'(pc + lut_m[idx]) : lut_m[idx];
    return {t, g};
  endfunction

  task automatic push_exp(input logic [1:0] m, input logic c, input logic [4:0] idx, input logic [11:0] pc);
    logic [12:0] e;
    e = expect_of(m, c, idx, pc);
    exp_q.push_back(e);
    if (e[12]) exp_taken++;
    else exp_nt++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n = 0;
    while ((phase !== p) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    if (phase !== p) begin
      total++;
      bad++;
      $display("FAIL wait_phase: phase=%0d, required %0d within 20 cycles", phase, p);
    end
  endtask

  task automatic drive_req(input logic [1:0] m, input logic c, input logic [4:0] idx, input logic [11:0] pc);
    br_req = 1'b1; br_mode = m; br_cond = c; br_idx = idx; prog_ctr = pc;
    @(negedge clk);
    br_req = 1'b0;
  endtask

  task automatic lut_write(input logic [4:0] a, input logic [11:0] d);
    lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
    @(negedge clk);
    lut_we = 1'b0;
    lut_m[a] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if ({branchFlag, target, phase, busy} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs: flag=%0b target=%h phase=%0d busy=%0b, required all 0",
               branchFlag, target, phase, busy);
    end
`ifdef BRANCH_CTRL_STATS_EN
    total++;
    if ({taken_cnt, nottaken_cnt, dropped_cnt} !== 48'd0) begin
      bad++;
      $display("FAIL reset_stats: %0d %0d %0d, required 0 0 0", taken_cnt, nottaken_cnt, dropped_cnt);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_absolute();
    lut_write(5'd3, 12'h0A5);
    wait_phase(3'd1);
    push_exp(2'b00, 1'b0, 5'd3, 12'h000);
    drive_req(2'b00, 1'b0, 5'd3, 12'h000);
    total++;
    if ({phase, busy} !== {3'd2, 1'b1}) begin
      bad++;
      $display("FAIL abs_busy: phase=%0d busy=%0b, required phase 2 busy 1", phase, busy);
    end
    tick();
    total++;
    if ({branchFlag, busy} !== 2'b01) begin
      bad++;
      $display("FAIL abs_ph3: flag=%0b busy=%0b, required flag 0 busy 1", branchFlag, busy);
    end
    tick();
    total++;
    if ({branchFlag, target} !== {1'b1, 12'h0A5}) begin
      bad++;
      $display("FAIL abs_fire: flag=%0b target=%h, required 1 0a5", branchFlag, target);
    end
    tick();
    total++;
    if ({branchFlag, busy, phase, target} !== {1'b0, 1'b0, 3'd0, 12'h0A5}) begin
      bad++;
      $display("FAIL abs_after: flag=%0b busy=%0b phase=%0d target=%h, required 0 0 0 0a5",
               branchFlag, busy, phase, target);
    end
  endtask

  task automatic test_conditional();
    wait_phase(3'd0);
    push_exp(2'b01, 1'b0, 5'd3, 12'h000);
    drive_req(2'b01, 1'b0, 5'd3, 12'h000);
    wait_phase(LAST);
    total++;
    if ({branchFlag, busy, target} !== {1'b0, 1'b1, 12'h0A5}) begin
      bad++;
      $display("FAIL cond0_fire: flag=%0b busy=%0b target=%h, required 0 1 0a5", branchFlag, busy, target);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL cond0_idle: busy=%0b, required 0", busy);
    end
    wait_phase(3'd1);
    push_exp(2'b01, 1'b1, 5'd3, 12'h000);
    drive_req(2'b01, 1'b1, 5'd3, 12'h000);
    wait_phase(LAST);
    total++;
    if (branchFlag !== 1'b1) begin
      bad++;
      $display("FAIL cond1_fire: flag=%0b, required 1", branchFlag);
    end
    wait_phase(3'd0);
    push_exp(2'b10, 1'b0, 5'd3, 12'h000);
    drive_req(2'b10, 1'b0, 5'd3, 12'h000);
    wait_phase(LAST);
    total++;
    if (branchFlag !== 1'b1) begin
      bad++;
      $display("FAIL ncond_fire: flag=%0b, required 1", branchFlag);
    end
  endtask

  task automatic test_relative();
    lut_write(5'd7, 12'h004);
    wait_phase(3'd0);
    push_exp(2'b11, 1'b0, 5'd7, 12'hFFE);
    drive_req(2'b11, 1'b0, 5'd7, 12'hFFE);
    wait_phase(LAST);
    total++;
    if (target !== 12'h002) begin
      bad++;
      $display("FAIL rel_wrap: target=%h, required 002", target);
    end
    lut_write(5'd7, 12'hFFC);
    wait_phase(3'd1);
    push_exp(2'b11, 1'b0, 5'd7, 12'h010);
    drive_req(2'b11, 1'b0, 5'd7, 12'h010);
    wait_phase(LAST);
    total++;
    if (target !== 12'h00C) begin
      bad++;
      $display("FAIL rel_neg: target=%h, required 00c", target);
    end
  endtask

  task automatic test_drop();
`ifdef BRANCH_CTRL_STATS_EN
    logic [15:0] d0;
`endif
    tick();
    wait_phase(LAST);
`ifdef BRANCH_CTRL_STATS_EN
    d0 = dropped_cnt;
`endif
    exp_drop++;
    drive_req(2'b00, 1'b0, 5'd7, 12'h000);
    push_exp(2'b00, 1'b0, 5'd3, 12'h000);
    drive_req(2'b00, 1'b0, 5'd3, 12'h000);
    tick();
    exp_drop++;
    drive_req(2'b00, 1'b0, 5'd7, 12'h000);
    wait_phase(LAST);
    total++;
    if ({branchFlag, target} !== {1'b1, 12'h0A5}) begin
      bad++;
      $display("FAIL drop_first_wins: flag=%0b target=%h, required 1 0a5", branchFlag, target);
    end
    tick();
`ifdef BRANCH_CTRL_STATS_EN
    total++;
    if (16'(dropped_cnt - d0) !== 16'd2) begin
      bad++;
      $display("FAIL drop_count: delta=%0d, required 2", 16'(dropped_cnt - d0));
    end
`endif
  endtask

  task automatic test_same_clock_lut();
    lut_write(5'd5, 12'h222);
    wait_phase(3'd1);
    lut_we = 1'b1; lut_waddr = 5'd5; lut_wdata = 12'h111;
    push_exp(2'b00, 1'b0, 5'd5, 12'h000);
    drive_req(2'b00, 1'b0, 5'd5, 12'h000);
    lut_we = 1'b0;
    lut_m[5] = 12'h111;
    wait_phase(LAST);
    total++;
    if (target !== 12'h222) begin
      bad++;
      $display("FAIL lut_old: target=%h, required 222", target);
    end
    wait_phase(3'd1);
    push_exp(2'b00, 1'b0, 5'd5, 12'h000);
    drive_req(2'b00, 1'b0, 5'd5, 12'h000);
    wait_phase(LAST);
    total++;
    if (target !== 12'h111) begin
      bad++;
      $display("FAIL lut_new: target=%h, required 111", target);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    wait_phase(3'd3);
    push_exp(2'b00, 1'b0, 5'd3, 12'h000);
    drive_req(2'b00, 1'b0, 5'd3, 12'h000);
    total++;
    if ({phase, branchFlag, target} !== {LAST, 1'b1, 12'h0A5}) begin
      bad++;
      $display("FAIL late_capture: phase=%0d flag=%0b target=%h, required 4 1 0a5", phase, branchFlag, target);
    end
    tick();
    push_exp(2'b11, 1'b0, 5'd7, 12'h100);
    drive_req(2'b11, 1'b0, 5'd7, 12'h100);
    wait_phase(LAST);
    total++;
    if ({branchFlag, target} !== {1'b1, 12'h0FC}) begin
      bad++;
      $display("FAIL b2b_rel: flag=%0b target=%h, required 1 0fc", branchFlag, target);
    end
  endtask

  task automatic test_reset_mid();
`ifdef BRANCH_CTRL_STATS_EN
    total++;
    if ({taken_cnt, nottaken_cnt, dropped_cnt} !== {16'(exp_taken), 16'(exp_nt), 16'(exp_drop)}) begin
      bad++;
      $display("FAIL stats: taken=%0d nt=%0d drop=%0d, required %0d %0d %0d",
               taken_cnt, nottaken_cnt, dropped_cnt, exp_taken, exp_nt, exp_drop);
    end
`endif
    wait_phase(3'd1);
    drive_req(2'b00, 1'b0, 5'd3, 12'h000);
    wait_phase(3'd3);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pending: busy=%0b, required 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_taken = 0; exp_nt = 0; exp_drop = 0;
    for (int i = 0; i < 32; i++) lut_m[i] = '0;
    total++;
    if ({branchFlag, busy, phase, target} !== 17'd0) begin
      bad++;
      $display("FAIL mid_reset: flag=%0b busy=%0b phase=%0d target=%h, required all 0",
               branchFlag, busy, phase, target);
    end
    repeat (8) tick();
    wait_phase(3'd1);
    push_exp(2'b00, 1'b0, 5'd3, 12'h000);
    drive_req(2'b00, 1'b0, 5'd3, 12'h000);
    wait_phase(LAST);
    total++;
    if ({branchFlag, target} !== {1'b1, 12'h000}) begin
      bad++;
      $display("FAIL lut_cleared: flag=%0b target=%h, required 1 000", branchFlag, target);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) lut_m[i] = '0;
    test_reset();
    test_absolute();
    test_conditional();
    test_relative();
    test_drop();
    test_same_clock_lut();
    test_back_to_back();
    test_reset_mid();
    repeat (3) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected fires outstanding, required 0", exp_q.size());
    end
`ifdef BRANCH_CTRL_STATS_EN
    total++;
    if ({taken_cnt, nottaken_cnt, dropped_cnt} !== {16'(exp_taken), 16'(exp_nt), 16'(exp_drop)}) begin
      bad++;
      $display("FAIL stats_final: taken=%0d nt=%0d drop=%0d, required %0d %0d %0d",
               taken_cnt, nottaken_cnt, dropped_cnt, exp_taken, exp_nt, exp_drop);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
